// File: rtl/crc_pkg.sv
// Shared Ethernet CRC-32 constants and the reflected byte-update function.
// The framing blocks (decapsulation check, encapsulation FCS generation)
// import this package so both sides use the same update function.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // Absorb one octet, LSB first, into a reflected CRC-32 remainder.
    function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc,
                                                    input logic [7:0]  d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_comb_byte_step.sv
// Combinational single-octet CRC-32 update step.
module crc32_byte_step
    import crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight unrolled LSB-first shift/XOR steps of the reflected polynomial.
    always_comb begin
        crc_out = crc32_next_byte(crc_in, data);
    end

endmodule

// File: rtl/crc32_comb.sv
// Byte-wide Ethernet CRC-32 engine. Holds a running reflected remainder and
// presents the finished FCS in receiver assembly order (first wire octet in
// result[31:24]) so a frame check is a plain 32-bit compare.
module crc32_comb
    import crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        updatecrc,
    input  logic [7:0]  data,
    output logic [31:0] result,
    output logic [7:0]  crc_lsb
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_step;
    logic [31:0] fcs;

    crc32_byte_step u_step (
        .crc_in  (crc_q),
        .data    (data),
        .crc_out (crc_step)
    );

    // Next remainder: absorb the octet when enabled, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (updatecrc) begin
            crc_d = crc_step;
        end
    end

    // Remainder register; reset wins over an update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // Outputs depend only on the registered remainder; low FCS byte goes
    // out first on the wire, so it lands in the top byte of result.
    always_comb begin
        fcs     = ~crc_q;
        result  = {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};
        crc_lsb = fcs[7:0];
    end

endmodule

// File: tb/tb_crc32_comb.sv
// Self-checking bench for crc32_comb with a bit-serial reference model.
module tb_crc32_comb;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic        updatecrc;
    logic [7:0]  data;
    logic [31:0] result;
    logic [7:0]  crc_lsb;

    int n_checks;
    int n_fail;

    crc32_comb dut (
        .clk       (clk),
        .rst       (rst),
        .updatecrc (updatecrc),
        .data      (data),
        .result    (result),
        .crc_lsb   (crc_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MSB-first shift register with the normal polynomial, fed
    // the wire bit stream; the standard CRC is the bit-reversed complement.
    function automatic logic [31:0] ref_result(input bq_t q);
        logic [31:0] r;
        logic [31:0] rev;
        logic [31:0] std;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (q[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = r[31] ^ q[k][i];
                r  = r << 1;
                if (fb) r = r ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) rev[i] = r[31-i];
        std = ~rev;
        return {std[7:0], std[15:8], std[23:16], std[31:24]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        updatecrc = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic absorb(input logic [7:0] b);
        updatecrc = 1'b1;
        data = b;
        tick();
        updatecrc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (result !== 32'h00000000) begin
            n_fail++;
            $display("FAIL reset_result: got %08h expected 00000000", result);
        end
        n_checks++;
        if (crc_lsb !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_crc_lsb: got %02h expected 00", crc_lsb);
        end
        tick();
        tick();
        n_checks++;
        if (result !== 32'h00000000) begin
            n_fail++;
            $display("FAIL reset_hold: got %08h expected 00000000", result);
        end
    endtask

    task automatic test_check_string();
        bq_t q;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            q.push_back(8'h31 + 8'(i));
            absorb(8'h31 + 8'(i));
            n_checks++;
            if (result !== ref_result(q)) begin
                n_fail++;
                $display("FAIL check_string_step%0d: got %08h expected %08h", i, result, ref_result(q));
            end
        end
        n_checks++;
        if (result !== 32'h2639F4CB) begin
            n_fail++;
            $display("FAIL check_string_final: got %08h expected 2639F4CB", result);
        end
        n_checks++;
        if (crc_lsb !== 8'h26) begin
            n_fail++;
            $display("FAIL check_string_lsb: got %02h expected 26", crc_lsb);
        end
    endtask

    task automatic test_single_octets();
        do_reset();
        absorb(8'h00);
        n_checks++;
        if (result !== 32'h8DEF02D2) begin
            n_fail++;
            $display("FAIL single_00: got %08h expected 8DEF02D2", result);
        end
        do_reset();
        absorb(8'h61);
        n_checks++;
        if (result !== 32'h43BEB7E8) begin
            n_fail++;
            $display("FAIL single_61: got %08h expected 43BEB7E8", result);
        end
        n_checks++;
        if (crc_lsb !== 8'h43) begin
            n_fail++;
            $display("FAIL single_61_lsb: got %02h expected 43", crc_lsb);
        end
    endtask

    task automatic test_idle_gaps();
        bq_t q;
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            q.push_back(8'h31 + 8'(i));
            absorb(8'h31 + 8'(i));
            exp = ref_result(q);
            for (int g = 0; g < 3; g++) begin
                data = 8'($urandom);
                tick();
                n_checks++;
                if (result !== exp) begin
                    n_fail++;
                    $display("FAIL idle_hold_d%0d_g%0d: got %08h expected %08h", i, g, result, exp);
                end
            end
        end
        n_checks++;
        if (result !== 32'h2639F4CB) begin
            n_fail++;
            $display("FAIL idle_final: got %08h expected 2639F4CB", result);
        end
    endtask

    task automatic test_residue();
        logic [7:0] fcs_b[4];
        fcs_b = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        do_reset();
        for (int i = 0; i < 9; i++) absorb(8'h31 + 8'(i));
        for (int i = 0; i < 4; i++) absorb(fcs_b[i]);
        n_checks++;
        if (result !== 32'h1CDF4421) begin
            n_fail++;
            $display("FAIL residue: got %08h expected 1CDF4421", result);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        absorb(8'h12);
        absorb(8'h34);
        absorb(8'h56);
        rst = 1'b1;
        updatecrc = 1'b1;
        data = 8'h55;
        tick();
        rst = 1'b0;
        updatecrc = 1'b0;
        n_checks++;
        if (result !== 32'h00000000) begin
            n_fail++;
            $display("FAIL rst_over_update: got %08h expected 00000000", result);
        end
        absorb(8'h61);
        n_checks++;
        if (result !== 32'h43BEB7E8) begin
            n_fail++;
            $display("FAIL fresh_after_rst: got %08h expected 43BEB7E8", result);
        end
    endtask

    task automatic test_no_comb_path();
        do_reset();
        absorb(8'h61);
        updatecrc = 1'b1;
        data = 8'hA5;
        #2;
        n_checks++;
        if (result !== 32'h43BEB7E8) begin
            n_fail++;
            $display("FAIL no_comb_path: got %08h expected 43BEB7E8", result);
        end
        updatecrc = 1'b0;
        tick();
    endtask

    task automatic test_random_frames();
        bq_t q;
        logic [31:0] exp;
        int len;
        logic [7:0] b;
        for (int f = 0; f < 20; f++) begin
            do_reset();
            q.delete();
            len = int'($urandom_range(0, 24));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                absorb(b);
                if ($urandom_range(0, 3) == 0) begin
                    data = 8'($urandom);
                    tick();
                end
            end
            exp = ref_result(q);
            n_checks++;
            if (result !== exp || crc_lsb !== exp[31:24]) begin
                n_fail++;
                $display("FAIL random_frame%0d len%0d: got %08h/%02h expected %08h/%02h",
                         f, len, result, crc_lsb, exp, exp[31:24]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        updatecrc = 1'b0;
        data      = 8'h00;
        #1;
        test_reset();
        test_check_string();
        test_single_octets();
        test_idle_gaps();
        test_residue();
        test_reset_midstream();
        test_no_comb_path();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
